// File: rtl/alarm_slot_scheduler.sv
// rtl/alarm_slot_scheduler.sv - four-slot alarm scheduler with ring, snooze and stop sequencing
module alarm_slot_scheduler #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 60,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       reset,
    input  logic       clk_1s,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    input  logic [3:0] cur_s1,
    input  logic [3:0] cur_s0,
    input  logic       ld_slot,
    input  logic [1:0] slot_sel,
    input  logic [1:0] set_h1,
    input  logic [3:0] set_h0,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_m0,
    input  logic       set_en,
    input  logic       snooze_req,
    input  logic       stop_req,
    output logic       alarm,
    output logic [1:0] active_slot,
    output logic [2:0] snooze_cnt,
    output logic [1:0] state
);

    localparam logic [1:0]  ST_IDLE    = 2'b00;
    localparam logic [1:0]  ST_RING    = 2'b01;
    localparam logic [1:0]  ST_SNOOZE  = 2'b10;
    localparam logic [2:0]  MAX_CNT    = 3'(MAX_SNOOZE);
    localparam logic [7:0]  RING_LAST  = 8'(RING_TIMEOUT - 1);
    localparam logic [11:0] SNOOZE_ADD = 12'(SNOOZE_MIN);

    logic [10:0] slot_mod [4];
    logic [3:0]  slot_en;
    logic [10:0] wake;
    logic [7:0]  ring_cnt;

    logic [10:0] cur_mod;
    logic [10:0] set_mod;
    logic        set_valid;
    logic        at_zero;
    logic        hit;
    logic [1:0]  win;
    logic        match;
    logic [11:0] wake_sum;
    logic [10:0] wake_wrap;

    logic [1:0]  state_nxt;
    logic [1:0]  slot_nxt;
    logic [2:0]  cnt_nxt;
    logic [7:0]  ring_nxt;
    logic [10:0] wake_nxt;

    assign cur_mod = ({9'd0, cur_h1} * 11'd10 + {7'd0, cur_h0}) * 11'd60
                   + {7'd0, cur_m1} * 11'd10 + {7'd0, cur_m0};
    assign set_mod = ({9'd0, set_h1} * 11'd10 + {7'd0, set_h0}) * 11'd60
                   + {7'd0, set_m1} * 11'd10 + {7'd0, set_m0};

    // Rejects non-BCD digits as well as out-of-range hours and minutes.
    assign set_valid = (set_h0 <= 4'd9) && (set_m1 <= 4'd5) && (set_m0 <= 4'd9)
                    && ((set_h1 < 2'd2) || ((set_h1 == 2'd2) && (set_h0 <= 4'd3)));

    assign at_zero   = (cur_s1 == 4'd0) && (cur_s0 == 4'd0);
    assign wake_sum  = {1'b0, cur_mod} + SNOOZE_ADD;
    assign wake_wrap = (wake_sum >= 12'd1440) ? 11'(wake_sum - 12'd1440) : wake_sum[10:0];

    // Descending scan so the lowest matching index is the one left in win.
    always_comb begin
        hit = 1'b0;
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_en[i] && (slot_mod[i] == cur_mod)) begin
                hit = 1'b1;
                win = 2'(i);
            end
        end
    end

    assign match = hit && at_zero;

    always_comb begin
        state_nxt = state;
        slot_nxt  = active_slot;
        cnt_nxt   = snooze_cnt;
        ring_nxt  = ring_cnt;
        wake_nxt  = wake;
        case (state)
            ST_IDLE: begin
                if (match) begin
                    state_nxt = ST_RING;
                    slot_nxt  = win;
                    cnt_nxt   = 3'd0;
                    ring_nxt  = 8'd0;
                end
            end
            ST_RING: begin
                if (stop_req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 3'd0;
                end else if (snooze_req && (snooze_cnt < MAX_CNT)) begin
                    state_nxt = ST_SNOOZE;
                    wake_nxt  = wake_wrap;
                    cnt_nxt   = snooze_cnt + 3'd1;
                end else if (ring_cnt == RING_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    ring_nxt = ring_cnt + 8'd1;
                end
            end
            ST_SNOOZE: begin
                if (stop_req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 3'd0;
                end else if (at_zero && (cur_mod == wake)) begin
                    state_nxt = ST_RING;
                    ring_nxt  = 8'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            alarm       <= 1'b0;
            active_slot <= 2'd0;
            snooze_cnt  <= 3'd0;
            ring_cnt    <= 8'd0;
            wake        <= 11'd0;
            slot_en     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                slot_mod[i] <= 11'd0;
            end
        end else begin
            state       <= state_nxt;
            alarm       <= (state_nxt == ST_RING);
            active_slot <= slot_nxt;
            snooze_cnt  <= cnt_nxt;
            ring_cnt    <= ring_nxt;
            wake        <= wake_nxt;
            // Slot writes land after this edge's match used the old contents.
            if (ld_slot && set_valid) begin
                slot_mod[slot_sel] <= set_mod;
                slot_en[slot_sel]  <= set_en;
            end
        end
    end

endmodule

// File: tb/tb_alarm_slot_scheduler.sv
// tb/tb_alarm_slot_scheduler.sv - table, corner-case and randomized checks of alarm_slot_scheduler
module tb_alarm_slot_scheduler;

    localparam int SNZ = 5;
    localparam int RT  = 60;
    localparam int MX  = 3;

    logic       reset, clk_1s;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
    logic       ld_slot;
    logic [1:0] slot_sel;
    logic [1:0] set_h1;
    logic [3:0] set_h0, set_m1, set_m0;
    logic       set_en, snooze_req, stop_req;
    logic       alarm;
    logic [1:0] active_slot;
    logic [2:0] snooze_cnt;
    logic [1:0] state;

    alarm_slot_scheduler #(.SNOOZE_MIN(SNZ), .RING_TIMEOUT(RT), .MAX_SNOOZE(MX)) dut (
        .reset(reset), .clk_1s(clk_1s),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .cur_s1(cur_s1), .cur_s0(cur_s0),
        .ld_slot(ld_slot), .slot_sel(slot_sel),
        .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1), .set_m0(set_m0),
        .set_en(set_en), .snooze_req(snooze_req), .stop_req(stop_req),
        .alarm(alarm), .active_slot(active_slot), .snooze_cnt(snooze_cnt), .state(state)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 ringing, 2 snoozed; times in minutes of day.
    int m_state, m_slot, m_cnt, m_ring, m_wake;
    int s_mod [4];
    bit s_en  [4];

    typedef struct {
        int t;
        bit ld;
        int sel, sh1, sh0, sm1, sm0;
        bit en, snz, stp;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic int ts(int h, int m, int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [7:0] ev(int st, int slot, int cnt);
        return {st == 1, 2'(st), 2'(slot), 3'(cnt)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {alarm, state, active_slot, snooze_cnt};
    endfunction

    function automatic logic [7:0] model_vec();
        return ev(m_state, m_slot, m_cnt);
    endfunction

    task automatic model_reset();
        m_state = 0; m_slot = 0; m_cnt = 0; m_ring = 0; m_wake = 0;
        for (int i = 0; i < 4; i++) begin
            s_mod[i] = 0;
            s_en[i]  = 0;
        end
    endtask

    task automatic model_step(int cur, bit zero, bit ld, int sel, int sh1, int sh0,
                              int sm1, int sm0, bit en, bit snz, bit stp);
        int w;
        w = -1;
        for (int i = 0; i < 4; i++)
            if (w < 0 && zero && s_en[i] && s_mod[i] == cur) w = i;
        if (m_state == 0) begin
            if (w >= 0) begin
                m_state = 1; m_slot = w; m_cnt = 0; m_ring = 0;
            end
        end else if (m_state == 1) begin
            if (stp) begin
                m_state = 0; m_cnt = 0;
            end else if (snz && m_cnt < MX) begin
                m_state = 2; m_wake = (cur + SNZ) % 1440; m_cnt++;
            end else if (m_ring == RT - 1) begin
                m_state = 0; m_cnt = 0;
            end else begin
                m_ring++;
            end
        end else begin
            if (stp) begin
                m_state = 0; m_cnt = 0;
            end else if (zero && cur == m_wake) begin
                m_state = 1; m_ring = 0;
            end
        end
        if (ld && sh0 <= 9 && sm1 <= 5 && sm0 <= 9 && (sh1 * 10 + sh0) <= 23) begin
            s_mod[sel] = (sh1 * 10 + sh0) * 60 + sm1 * 10 + sm0;
            s_en[sel]  = en;
        end
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {alarm,state,slot,cnt}=%b want %b", name, act, exp);
        end
    endtask

    task automatic drive(int t, bit ld, int sel, int sh1, int sh0, int sm1, int sm0,
                         bit en, bit snz, bit stp);
        int h, m, s;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        cur_h1 = 2'(h / 10); cur_h0 = 4'(h % 10);
        cur_m1 = 4'(m / 10); cur_m0 = 4'(m % 10);
        cur_s1 = 4'(s / 10); cur_s0 = 4'(s % 10);
        ld_slot = ld; slot_sel = 2'(sel);
        set_h1 = 2'(sh1); set_h0 = 4'(sh0); set_m1 = 4'(sm1); set_m0 = 4'(sm0);
        set_en = en; snooze_req = snz; stop_req = stp;
        model_step(h * 60 + m, s == 0, ld, sel, sh1, sh0, sm1, sm0, en, snz, stp);
        @(posedge clk_1s);
        #1;
    endtask

    task automatic tick(int t);
        drive(t, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic row(int t, bit ld, int sel, int sh1, int sh0, int sm1, int sm0,
                       bit en, bit snz, bit stp, int st, int slot, int cnt);
        vec_t v;
        v.t = t; v.ld = ld; v.sel = sel; v.sh1 = sh1; v.sh0 = sh0; v.sm1 = sm1; v.sm0 = sm0;
        v.en = en; v.snz = snz; v.stp = stp; v.exp = ev(st, slot, cnt);
        vecs.push_back(v);
    endtask

    initial begin
        int hi;
        row(ts(7,0,0),   1,0,0,7,3,0,1, 0,0, 0,0,0);
        row(ts(7,30,0),  0,0,0,0,0,0,0, 0,0, 1,0,0);
        row(ts(7,30,10), 0,0,0,0,0,0,0, 1,0, 2,0,1);
        row(ts(7,35,0),  0,0,0,0,0,0,0, 0,0, 1,0,1);
        row(ts(7,35,5),  0,0,0,0,0,0,0, 1,0, 2,0,2);
        row(ts(7,40,0),  0,0,0,0,0,0,0, 0,0, 1,0,2);
        row(ts(7,40,1),  0,0,0,0,0,0,0, 1,0, 2,0,3);
        row(ts(7,45,0),  0,0,0,0,0,0,0, 0,0, 1,0,3);
        row(ts(7,45,2),  0,0,0,0,0,0,0, 1,0, 1,0,3);
        row(ts(7,45,3),  0,0,0,0,0,0,0, 0,1, 0,0,0);
        row(ts(8,0,0),   1,1,1,2,0,0,1, 0,0, 0,0,0);
        row(ts(8,0,1),   1,3,1,2,0,0,1, 0,0, 0,0,0);
        row(ts(12,0,0),  0,0,0,0,0,0,0, 0,0, 1,1,0);
        row(ts(12,0,1),  0,0,0,0,0,0,0, 1,1, 0,1,0);
        row(ts(12,30,0), 1,2,1,3,0,0,1, 0,0, 0,1,0);
        row(ts(12,30,1), 1,2,2,4,1,0,1, 0,0, 0,1,0);
        row(ts(12,30,2), 1,2,1,2,6,10,1,0,0, 0,1,0);
        row(ts(13,0,0),  0,0,0,0,0,0,0, 0,0, 1,2,0);
        row(ts(13,0,1),  0,0,0,0,0,0,0, 0,1, 0,2,0);
        row(ts(13,0,2),  1,0,2,3,5,7,1, 0,0, 0,2,0);
        row(ts(23,57,0), 0,0,0,0,0,0,0, 0,0, 1,0,0);
        row(ts(23,57,30),0,0,0,0,0,0,0, 1,0, 2,0,1);
        row(ts(0,1,0),   0,0,0,0,0,0,0, 0,0, 2,0,1);
        row(ts(0,2,0),   0,0,0,0,0,0,0, 0,0, 1,0,1);
        row(ts(0,2,1),   0,0,0,0,0,0,0, 0,1, 0,0,0);
        row(ts(23,57,0), 1,0,0,6,0,0,1, 0,0, 1,0,0);
        row(ts(23,57,1), 0,0,0,0,0,0,0, 0,1, 0,0,0);
        row(ts(6,0,0),   0,0,0,0,0,0,0, 0,0, 1,0,0);
        row(ts(6,0,1),   0,0,0,0,0,0,0, 0,1, 0,0,0);
        row(ts(13,0,5),  0,0,0,0,0,0,0, 0,0, 0,0,0);
        row(ts(6,1,0),   1,0,0,6,0,0,0, 0,0, 0,0,0);
        row(ts(6,0,0),   0,0,0,0,0,0,0, 0,0, 0,0,0);
        row(ts(6,2,0),   1,0,0,6,0,0,1, 0,0, 0,0,0);

        reset = 1'b1;
        ld_slot = 0; slot_sel = 0; set_h1 = 0; set_h0 = 0; set_m1 = 0; set_m0 = 0;
        set_en = 0; snooze_req = 0; stop_req = 0;
        cur_h1 = 0; cur_h0 = 0; cur_m1 = 0; cur_m0 = 0; cur_s1 = 0; cur_s0 = 0;
        model_reset();
        #1;
        check("reset_state", dut_vec(), 8'd0);
        @(posedge clk_1s);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].t, vecs[i].ld, vecs[i].sel, vecs[i].sh1, vecs[i].sh0,
                  vecs[i].sm1, vecs[i].sm0, vecs[i].en, vecs[i].snz, vecs[i].stp);
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Unattended ring: high for exactly RT edges, then idle.
        hi = 0;
        tick(ts(6,0,0));
        check("timeout_start", dut_vec(), ev(1,0,0));
        if (alarm) hi++;
        for (int k = 1; k < RT; k++) begin
            tick(ts(6,0,k));
            if (alarm) hi++;
        end
        tick(ts(6,1,0));
        check("timeout_end", dut_vec(), ev(0,0,0));
        n_checks++;
        if (hi != RT) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d high edges want %0d", hi, RT);
        end

        // Asynchronous reset mid-ring wipes the slots.
        tick(ts(6,0,0));
        check("pre_reset_ring", dut_vec(), ev(1,0,0));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", dut_vec(), 8'd0);
        #2;
        reset = 1'b0;
        model_reset();
        tick(ts(6,0,0));
        check("slots_lost", dut_vec(), 8'd0);

        for (int n = 0; n < 400; n++) begin
            int sel, sh1, sh0, sm1, sm0, mn, sc, hh, mm;
            bit ld, en, snz, stp;
            ld = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 3);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                sh1 = $urandom_range(0, 3); sh0 = $urandom_range(0, 15);
                sm1 = $urandom_range(0, 15); sm0 = $urandom_range(0, 15);
            end else begin
                hh = $urandom_range(0, 23); mm = $urandom_range(0, 59);
                sh1 = hh / 10; sh0 = hh % 10; sm1 = mm / 10; sm0 = mm % 10;
            end
            case ($urandom_range(0, 3))
                0:       mn = s_mod[$urandom_range(0, 3)];
                1:       mn = m_wake;
                2:       mn = $urandom_range(0, 1439);
                default: mn = (m_wake + 1439) % 1440;
            endcase
            sc = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 59);
            snz = ($urandom_range(0, 7) == 0);
            stp = ($urandom_range(0, 15) == 0);
            drive(mn * 60 + sc, ld, sel, sh1, sh0, sm1, sm0, en, snz, stp);
            check($sformatf("rand%0d", n), dut_vec(), model_vec());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
